sec_input_cond: RTL and testbench



---
 rtl/sec_pkg.sv | 15 +
 rtl/sec_debounce_ch.sv | 110 +++++++++++
 rtl/sec_input_cond.sv | 74 +++++++
 tb/tb_sec_input_cond.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sec_pkg.sv
// Shared constants for the security input path: key encodings and ms tick divider.
// Imported by sec_debounce_ch and sec_input_cond.
package sec_pkg;

  localparam logic [1:0] KEY_DISARM = 2'b00;
  localparam logic [1:0] KEY_ARM    = 2'b11;
  localparam int         MS_PER_SEC = 1000;

  function automatic int tick_div(input int clk_freq);
    int d;
    d = clk_freq / MS_PER_SEC;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/sec_debounce_ch.sv
// One input channel: synchroniser, ms-based debounce, change/rise pulses, optional
// tamper edge counter (SEC_TAMPER_DETECT_EN). Ports: clk, rst, ms_tick, raw -> stable, chg, rise, tamper_hit.
module sec_debounce_ch
  import sec_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int DEBOUNCE_MS   = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int TAMPER_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             chg,
  output logic             rise,
  output logic             tamper_hit
);

  localparam int CW = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sff;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] pre;
  logic bounce;
  logic load;
  logic upd;

  assign sync = sff[SYNC_STAGES-1];
  assign pre  = sff[SYNC_STAGES-2];
  // Looking one stage ahead lets the window start on the
  // first cycle the new value is visible at sync.
  assign bounce = sync != pre;
  assign upd    = load && (sync != stable);

  always_ff @(posedge clk) begin
    if (rst) sff <= '0;
    else     sff <= {sff[SYNC_STAGES-2:0], raw};
  end

`ifdef SEC_TAMPER_DETECT_EN
  logic quiet;
`endif

  if (DEBOUNCE_MS == 0) begin : g_nodb
    logic unused_tick;
    assign unused_tick = ms_tick;
    assign load = 1'b1;
`ifdef SEC_TAMPER_DETECT_EN
    assign quiet = 1'b0;
`endif
  end else begin : g_db
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_MS - 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst)                          cnt <= '0;
      else if (sync == stable || bounce) cnt <= '0;
      else if (ms_tick)                 cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign load = !bounce && ms_tick && (cnt == LAST);

`ifdef SEC_TAMPER_DETECT_EN
    // Quiet window: sync matched stable for a whole debounce period.
    logic [CW-1:0] qcnt;
    always_ff @(posedge clk) begin
      if (rst)                           qcnt <= '0;
      else if (sync != stable || bounce) qcnt <= '0;
      else if (ms_tick)                  qcnt <= (qcnt == LAST) ? '0 : qcnt + 1'b1;
    end
    assign quiet = ms_tick && !bounce && (sync == stable) && (qcnt == LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      chg    <= 1'b0;
      rise   <= 1'b0;
    end else begin
      chg  <= upd;
      rise <= upd && (&sync) && ~|stable;
      if (upd) stable <= sync;
    end
  end

`ifdef SEC_TAMPER_DETECT_EN
  localparam int EW = $clog2(TAMPER_THRESH + 1);
  localparam logic [EW-1:0] THR = EW'(TAMPER_THRESH);
  logic [EW-1:0] ecnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt <= '0;
    end else if (bounce) begin
      if (ecnt != THR) ecnt <= ecnt + 1'b1;
    end else if (upd || quiet) begin
      ecnt <= '0;
    end
  end

  assign tamper_hit = (ecnt == THR);
`else
  localparam int unused_thresh = TAMPER_THRESH;
  assign tamper_hit = 1'b0;
`endif

endmodule

// File: rtl/sec_input_cond.sv
// Input conditioning ahead of the security FSM: shared ms tick, three debounced channels.
// Ports: CLK, RST, KEY_RAW/DOOR_RAW/WINDOW_RAW -> KEY, DOOR, WINDOW, KEY_CHG, DOOR_RISE, WINDOW_RISE, TAMPER (SEC_TAMPER_DETECT_EN).
module sec_input_cond
  import sec_pkg::*;
#(
  parameter int CLK_FREQ      = 125_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int TAMPER_THRESH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY_RAW,
  input  logic       DOOR_RAW,
  input  logic       WINDOW_RAW,
  output logic [1:0] KEY,
  output logic       DOOR,
  output logic       WINDOW,
  output logic       KEY_CHG,
  output logic       DOOR_RISE,
  output logic       WINDOW_RISE,
  output logic       TAMPER
);

  localparam int TICK_DIV = tick_div(CLK_FREQ);
  localparam int TW       = $clog2(TICK_DIV + 1);

  logic [TW-1:0] tcnt;
  logic ms_tick;

  assign ms_tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) tcnt <= '0;
    else     tcnt <= ms_tick ? '0 : tcnt + 1'b1;
  end

  logic key_hit, door_hit, win_hit;
  logic key_rise, door_chg, win_chg;
  logic unused_pulses;

  assign unused_pulses = ^{key_rise, door_chg, win_chg};

  sec_debounce_ch #(
    .WIDTH(2), .DEBOUNCE_MS(DEBOUNCE_MS),
    .SYNC_STAGES(SYNC_STAGES), .TAMPER_THRESH(TAMPER_THRESH)
  ) u_key (
    .clk(CLK), .rst(RST), .ms_tick(ms_tick), .raw(KEY_RAW),
    .stable(KEY), .chg(KEY_CHG), .rise(key_rise), .tamper_hit(key_hit)
  );

  sec_debounce_ch #(
    .WIDTH(1), .DEBOUNCE_MS(DEBOUNCE_MS),
    .SYNC_STAGES(SYNC_STAGES), .TAMPER_THRESH(TAMPER_THRESH)
  ) u_door (
    .clk(CLK), .rst(RST), .ms_tick(ms_tick), .raw(DOOR_RAW),
    .stable(DOOR), .chg(door_chg), .rise(DOOR_RISE), .tamper_hit(door_hit)
  );

  sec_debounce_ch #(
    .WIDTH(1), .DEBOUNCE_MS(DEBOUNCE_MS),
    .SYNC_STAGES(SYNC_STAGES), .TAMPER_THRESH(TAMPER_THRESH)
  ) u_win (
    .clk(CLK), .rst(RST), .ms_tick(ms_tick), .raw(WINDOW_RAW),
    .stable(WINDOW), .chg(win_chg), .rise(WINDOW_RISE), .tamper_hit(win_hit)
  );

  // Sticky until reset; hits are constant 0 when detection is compiled out.
  always_ff @(posedge CLK) begin
    if (RST)                            TAMPER <= 1'b0;
    else if (key_hit | door_hit | win_hit) TAMPER <= 1'b1;
  end

endmodule

// File: tb/tb_sec_input_cond.sv
// Bench for sec_input_cond at 10 kHz / 3 ms debounce / 2 sync stages.
// Window-based reference model plus directed latency and pulse checks.
module tb_sec_input_cond;
  import sec_pkg::*;

  localparam int T  = 10;
  localparam int DB = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] KEY_RAW;
  logic       DOOR_RAW, WINDOW_RAW;
  logic [1:0] KEY;
  logic       DOOR, WINDOW, KEY_CHG, DOOR_RISE, WINDOW_RISE, TAMPER;

  sec_input_cond #(
    .CLK_FREQ(10_000), .DEBOUNCE_MS(DB), .SYNC_STAGES(2), .TAMPER_THRESH(8)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY_RAW(KEY_RAW), .DOOR_RAW(DOOR_RAW),
    .WINDOW_RAW(WINDOW_RAW), .KEY(KEY), .DOOR(DOOR), .WINDOW(WINDOW),
    .KEY_CHG(KEY_CHG), .DOOR_RISE(DOOR_RISE), .WINDOW_RISE(WINDOW_RISE),
    .TAMPER(TAMPER)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int rst_e  = 0;
  int tamper_exp = 0;
  int kchg_cnt = 0, wrise_cnt = 0, partial = 0;

  logic [1:0] lastv[3];
  logic [1:0] stab[3];
  int         chg_e[3];
  logic       m_pulse[3];
  logic       m_rise[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                 name, act, exp, edge_n);
    end
  endtask

  function automatic logic [1:0] raw_of(input int c);
    case (c)
      0:       return KEY_RAW;
      1:       return {1'b0, DOOR_RAW};
      default: return {1'b0, WINDOW_RAW};
    endcase
  endfunction

  // A value is accepted on the tick that completes DB whole ticks
  // counted from two edges after it appeared at the pins (or from
  // reset release), provided it has not changed in between.
  always @(posedge CLK) begin
    int a;
    int nt;
    edge_n++;
    for (int c = 0; c < 3; c++) begin
      m_pulse[c] = 1'b0;
      m_rise[c]  = 1'b0;
      if (RST) begin
        lastv[c] = 2'b00;
        chg_e[c] = edge_n;
        stab[c]  = 2'b00;
      end else begin
        a = chg_e[c] + 2;
        if (a < rst_e + 1) a = rst_e + 1;
        nt = (edge_n - rst_e) / T - (a - 1 - rst_e) / T;
        if (lastv[c] != stab[c] && edge_n >= a &&
            (edge_n - rst_e) % T == 0 && nt == DB) begin
          m_pulse[c] = 1'b1;
          m_rise[c]  = (stab[c] == 2'b00) && (lastv[c] == 2'b01);
          stab[c]    = lastv[c];
        end
        if (raw_of(c) != lastv[c]) begin
          lastv[c] = raw_of(c);
          chg_e[c] = edge_n;
        end
      end
    end
    if (RST) rst_e = edge_n;
  end

  always @(negedge CLK) begin
    if (edge_n > 0) begin
      chk("key",         KEY,         stab[0]);
      chk("door",        DOOR,        stab[1][0]);
      chk("window",      WINDOW,      stab[2][0]);
      chk("key_chg",     KEY_CHG,     m_pulse[0]);
      chk("door_rise",   DOOR_RISE,   m_rise[1]);
      chk("window_rise", WINDOW_RISE, m_rise[2]);
      if (tamper_exp >= 0) chk("tamper", TAMPER, tamper_exp);
      if (KEY_CHG) kchg_cnt++;
      if (WINDOW_RISE) wrise_cnt++;
      if (KEY == 2'b01 || KEY == 2'b10) partial++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int lvl(input int sel);
    case (sel)
      0:       return KEY;
      1:       return DOOR;
      default: return WINDOW;
    endcase
  endfunction

  task automatic wait_lvl(input int sel, input int val, input int maxc,
                          output int lat);
    int start;
    start = edge_n;
    lat = -1;
    for (int i = 0; i < maxc; i++) begin
      cycles(1);
      if (lvl(sel) == val) begin
        lat = edge_n - start;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, exp_t;
    RST = 1'b1;
    KEY_RAW = 2'b11;
    DOOR_RAW = 1'b1;
    WINDOW_RAW = 1'b1;
    cycles(5);

    // 1: reset with all raw inputs high
    chk("t1_rst_key", KEY, KEY_DISARM);
    chk("t1_rst_door", DOOR, 0);
    chk("t1_rst_win", WINDOW, 0);
    RST = 1'b0;
    wait_lvl(0, KEY_ARM, 40, lat);
    chk("t1_lat", lat, 30);
    chk("t1_door", DOOR, 1);
    chk("t1_win", WINDOW, 1);

    // 2: door rise latency and pulse width
    DOOR_RAW = 1'b0;
    wait_lvl(1, 0, 40, lat);
    cycles(5);
    DOOR_RAW = 1'b1;
    wait_lvl(1, 1, 40, lat);
    chk("t2_lat_in_range", (lat >= 23 && lat <= 32) ? 1 : 0, 1);
    chk("t2_rise_on", DOOR_RISE, 1);
    cycles(1);
    chk("t2_rise_off", DOOR_RISE, 0);

    // 3: window glitches are rejected
    WINDOW_RAW = 1'b0;
    wait_lvl(2, 0, 40, lat);
    cycles(3);
    base = wrise_cnt;
    WINDOW_RAW = 1'b1;
    cycles(15);
    WINDOW_RAW = 1'b0;
    cycles(40);
    for (int i = 0; i < 3; i++) begin
      WINDOW_RAW = 1'b1;
      cycles(6);
      WINDOW_RAW = 1'b0;
      cycles(6);
    end
    cycles(50);
    chk("t3_window", WINDOW, 0);
    chk("t3_rises", wrise_cnt - base, 0);

    // 4: skewed key 00->11 gives one change
    KEY_RAW = 2'b00;
    wait_lvl(0, 0, 40, lat);
    cycles(3);
    base = kchg_cnt;
    partial = 0;
    KEY_RAW = 2'b01;
    cycles(5);
    KEY_RAW = 2'b11;
    wait_lvl(0, 3, 45, lat);
    cycles(5);
    chk("t4_key", KEY, KEY_ARM);
    chk("t4_pulses", kchg_cnt - base, 1);
    chk("t4_partial", partial, 0);

    // 5: reset discards a pending door change
    DOOR_RAW = 1'b0;
    wait_lvl(1, 0, 40, lat);
    cycles(3);
    DOOR_RAW = 1'b1;
    cycles(20);
    chk("t5_pending", DOOR, 0);
    RST = 1'b1;
    cycles(1);
    chk("t5_rst_door", DOOR, 0);
    RST = 1'b0;
    wait_lvl(1, 1, 40, lat);
    chk("t5_lat", lat, 30);

    // 6: rapid door toggling
    cycles(5);
    tamper_exp = -1;
    for (int i = 0; i < 8; i++) begin
      DOOR_RAW = ~DOOR_RAW;
      cycles(2);
    end
    cycles(20);
`ifdef SEC_TAMPER_DETECT_EN
    exp_t = 1;
`else
    exp_t = 0;
`endif
    chk("t6_tamper", TAMPER, exp_t);
    tamper_exp = exp_t;
    cycles(40);
    chk("t6_tamper_hold", TAMPER, exp_t);
    tamper_exp = -1;
    RST = 1'b1;
    cycles(2);
    tamper_exp = 0;
    chk("t6_tamper_rst", TAMPER, 0);
    RST = 1'b0;
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
